// File: rtl/decode_queue.sv
// RV32I + Zicsr + mret (+ optional RV32M) decode stage with a small output queue.
// Fetch enqueues decoded bundles; execute drains them; flush clears everything.
module decode_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter bit          ENABLE_M = 1'b1,
    parameter int unsigned PC_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_ins,
    input  logic [PC_W-1:0]          in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [31:0]              out_imm,
    output logic [4:0]               out_rs1_addr,
    output logic [4:0]               out_rs2_addr,
    output logic [4:0]               out_rd_addr,
    output logic [3:0]               out_alu_op,
    output logic                     out_rd_wen,
    output logic                     out_muldiv,
    output logic [2:0]               out_muldiv_op,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INS_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INS_MRET   = 32'h3020_0073;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_op;
        logic            rd_wen;
        logic            muldiv;
        logic [2:0]      muldiv_op;
        logic            illegal;
    } bundle_t;

    // Integer ALU op for OP/OP-IMM; alt selects SUB/SRA.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal;
    logic        writes;
    logic        is_m;
    logic [2:0]  fmt;
    logic [3:0]  alu;
    logic [31:0] imm;
    bundle_t     dec;

    assign opcode = in_ins[6:0];
    assign funct3 = in_ins[14:12];
    assign funct7 = in_ins[31:25];

    // Legality, destination use, immediate format and ALU op per opcode.
    always_comb begin
        legal  = 1'b0;
        writes = 1'b0;
        is_m   = 1'b0;
        fmt    = FMT_NONE;
        alu    = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                legal  = 1'b1;
                writes = 1'b1;
                fmt    = FMT_U;
                alu    = ALU_PASSB;
            end
            OPC_AUIPC: begin
                legal  = 1'b1;
                writes = 1'b1;
                fmt    = FMT_U;
            end
            OPC_JAL: begin
                legal  = 1'b1;
                writes = 1'b1;
                fmt    = FMT_J;
            end
            OPC_JALR: begin
                legal  = (funct3 == 3'd0);
                writes = 1'b1;
                fmt    = FMT_I;
            end
            OPC_BRANCH: begin
                legal = (funct3[2:1] != 2'b01);
                fmt   = FMT_B;
                alu   = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
            end
            OPC_LOAD: begin
                legal  = (funct3 != 3'd3) && (funct3[2:1] != 2'b11);
                writes = 1'b1;
                fmt    = FMT_I;
            end
            OPC_STORE: begin
                legal = !funct3[2] && (funct3[1:0] != 2'b11);
                fmt   = FMT_S;
            end
            OPC_OPIMM: begin
                writes = 1'b1;
                fmt    = FMT_I;
                alu    = arith_op(funct3, (funct3 == 3'd5) && funct7[5]);
                if (funct3 == 3'd1) begin
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'd5) begin
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end else begin
                    legal = 1'b1;
                end
            end
            OPC_OP: begin
                writes = 1'b1;
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                    alu   = arith_op(funct3, 1'b0);
                end else if (funct7 == 7'b0100000) begin
                    legal = (funct3 == 3'd0) || (funct3 == 3'd5);
                    alu   = arith_op(funct3, 1'b1);
                end else if (funct7 == 7'b0000001) begin
                    legal = ENABLE_M;
                    is_m  = ENABLE_M;
                end
            end
            OPC_FENCE: begin
                legal = (funct3 == 3'd0);
                fmt   = FMT_I;
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'd0) begin
                    legal = (in_ins == INS_ECALL) || (in_ins == INS_EBREAK) || (in_ins == INS_MRET);
                end else if (funct3 != 3'd4) begin
                    legal  = 1'b1;
                    writes = 1'b1;
                    fmt    = funct3[2] ? FMT_Z : FMT_I;
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Immediate extraction; formats without an immediate read all-ones.
    always_comb begin
        imm = '1;
        case (fmt)
            FMT_I:   imm = {{20{in_ins[31]}}, in_ins[31:20]};
            FMT_S:   imm = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
            FMT_B:   imm = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
            FMT_U:   imm = {in_ins[31:12], 12'h000};
            FMT_J:   imm = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};
            FMT_Z:   imm = {27'h0, in_ins[19:15]};
            default: imm = '1;
        endcase
    end

    always_comb begin
        dec.pc        = in_pc;
        dec.imm       = imm;
        dec.rs1       = in_ins[19:15];
        dec.rs2       = in_ins[24:20];
        dec.rd        = in_ins[11:7];
        dec.alu_op    = (legal && !is_m) ? alu : ALU_ADD;
        dec.rd_wen    = legal && writes && (in_ins[11:7] != 5'd0);
        dec.muldiv    = legal && is_m;
        dec.muldiv_op = (legal && is_m) ? funct3 : 3'd0;
        dec.illegal   = !legal;
    end

    bundle_t         mem [DEPTH];
    logic [AW-1:0]   head_q;
    logic [AW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic            valid_q;
    bundle_t         out_q;
    logic [AW-1:0]   head_n;
    logic [AW-1:0]   tail_n;
    logic [CW-1:0]   count_n;
    bundle_t         out_n;
    logic            full_c;
    logic            push_c;
    logic            pop_c;

    assign full_c   = (count_q == CW'(DEPTH));
    assign in_ready = !full_c || out_ready;
    assign push_c   = in_valid && in_ready && !flush;
    assign pop_c    = valid_q && out_ready && !flush;

    // Next pointers, occupancy and the bundle that will sit at the head.
    always_comb begin
        head_n  = head_q;
        tail_n  = tail_q;
        count_n = count_q;
        out_n   = out_q;
        if (flush) begin
            head_n  = '0;
            tail_n  = '0;
            count_n = '0;
            out_n   = '0;
        end else begin
            if (pop_c) begin
                head_n = head_q + AW'(1);
            end
            if (push_c) begin
                tail_n = tail_q + AW'(1);
            end
            count_n = count_q + CW'(push_c) - CW'(pop_c);
            // The entry being written becomes the head when nothing older remains.
            if (count_n == '0) begin
                out_n = '0;
            end else if (push_c && (head_n == tail_q)) begin
                out_n = dec;
            end else begin
                out_n = mem[head_n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= count_n;
            valid_q <= (count_n != '0);
            out_q   <= out_n;
        end
    end

    // Storage needs no reset; occupancy tracking masks stale entries.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[tail_q] <= dec;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = out_q.pc;
    assign out_imm       = out_q.imm;
    assign out_rs1_addr  = out_q.rs1;
    assign out_rs2_addr  = out_q.rs2;
    assign out_rd_addr   = out_q.rd;
    assign out_alu_op    = out_q.alu_op;
    assign out_rd_wen    = out_q.rd_wen;
    assign out_muldiv    = out_q.muldiv;
    assign out_muldiv_op = out_q.muldiv_op;
    assign out_illegal   = out_q.illegal;
    assign count         = count_q;

    // Fetch must hold an offered instruction until it is taken or flushed.
    a_hold_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready && !flush) |=> in_valid);

endmodule

// File: tb/tb_decode_queue.sv
// Randomised self-checking bench for decode_queue against a queue-based reference model.
module tb_decode_queue;

    localparam int unsigned DEPTH = 4;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                           A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                           A_OR = 4'd8, A_AND = 4'd9, A_PASSB = 4'd10;

    localparam int F_NONE = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5, F_Z = 6;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        wen;
        logic        md;
        logic [2:0]  mdop;
        logic        ill;
    } bun_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_ins, in_pc, out_pc, out_imm;
    logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
    logic [3:0]  out_alu_op;
    logic        out_rd_wen, out_muldiv, out_illegal;
    logic [2:0]  out_muldiv_op;
    logic [2:0]  count;

    logic        m0_in_valid, m0_in_ready, m0_flush, m0_out_valid, m0_out_ready;
    logic [31:0] m0_in_ins, m0_in_pc, m0_out_pc, m0_out_imm;
    logic [4:0]  m0_rs1, m0_rs2, m0_rd;
    logic [3:0]  m0_alu;
    logic        m0_wen, m0_md, m0_ill;
    logic [2:0]  m0_mdop;
    logic [1:0]  m0_count;

    int   n_vec = 0;
    int   n_err = 0;
    bun_t mq[$];
    bit   last_acc = 1'b0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1'b1), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ins(in_ins), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
        .out_alu_op(out_alu_op), .out_rd_wen(out_rd_wen), .out_muldiv(out_muldiv),
        .out_muldiv_op(out_muldiv_op), .out_illegal(out_illegal), .count(count)
    );

    decode_queue #(.DEPTH(2), .ENABLE_M(1'b0), .PC_W(32)) dut_m0 (
        .clk(clk), .rst_n(rst_n), .in_valid(m0_in_valid), .in_ready(m0_in_ready),
        .in_ins(m0_in_ins), .in_pc(m0_in_pc), .flush(m0_flush), .out_valid(m0_out_valid),
        .out_ready(m0_out_ready), .out_pc(m0_out_pc), .out_imm(m0_out_imm),
        .out_rs1_addr(m0_rs1), .out_rs2_addr(m0_rs2), .out_rd_addr(m0_rd),
        .out_alu_op(m0_alu), .out_rd_wen(m0_wen), .out_muldiv(m0_md),
        .out_muldiv_op(m0_mdop), .out_illegal(m0_ill), .count(m0_count)
    );

    // Reference decoder: classify the instruction, then build the bundle.
    function automatic bun_t ref_decode(logic [31:0] w, logic [31:0] pc, bit en_m);
        bun_t       b;
        logic [6:0] f7;
        logic [2:0] f3;
        bit         ok, wr, mop;
        int         fmt;
        logic [3:0] alu;
        logic [3:0] tab [8];
        tab = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        f7 = w[31:25];
        f3 = w[14:12];
        ok = 0; wr = 0; mop = 0; fmt = F_NONE; alu = A_ADD;
        case (w[6:0])
            7'h37: begin ok = 1; wr = 1; fmt = F_U; alu = A_PASSB; end
            7'h17: begin ok = 1; wr = 1; fmt = F_U; end
            7'h6F: begin ok = 1; wr = 1; fmt = F_J; end
            7'h67: begin ok = (f3 == 0); wr = 1; fmt = F_I; end
            7'h63: begin
                ok  = !(f3 inside {3'd2, 3'd3});
                fmt = F_B;
                alu = (f3 < 2) ? A_SUB : ((f3 < 6) ? A_SLT : A_SLTU);
            end
            7'h03: begin ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); wr = 1; fmt = F_I; end
            7'h23: begin ok = (f3 < 3); fmt = F_S; end
            7'h13: begin
                wr = 1; fmt = F_I; alu = tab[f3];
                ok = 1;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    ok = (f7 == 0) || (f7 == 7'h20);
                    if (f7 == 7'h20) alu = A_SRA;
                end
            end
            7'h33: begin
                wr = 1;
                if (f7 == 0) begin ok = 1; alu = tab[f3]; end
                else if (f7 == 7'h20) begin ok = (f3 == 0) || (f3 == 5); alu = (f3 == 0) ? A_SUB : A_SRA; end
                else if (f7 == 7'h01) begin ok = en_m; mop = en_m; alu = A_ADD; end
            end
            7'h0F: begin ok = (f3 == 0); fmt = F_I; end
            7'h73: begin
                if (f3 == 0) ok = (w == 32'h73) || (w == 32'h0010_0073) || (w == 32'h3020_0073);
                else if (f3 != 4) begin ok = 1; wr = 1; fmt = (f3 >= 5) ? F_Z : F_I; end
            end
            default: ok = 0;
        endcase
        b.pc   = pc;
        b.rs1  = w[19:15];
        b.rs2  = w[24:20];
        b.rd   = w[11:7];
        b.alu  = ok ? alu : A_ADD;
        b.wen  = ok && wr && (w[11:7] != 0);
        b.md   = ok && mop;
        b.mdop = b.md ? f3 : 3'd0;
        b.ill  = !ok;
        case (fmt)
            F_I:     b.imm = 32'($signed(w[31:20]));
            F_S:     b.imm = 32'($signed({w[31:25], w[11:7]}));
            F_B:     b.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            F_U:     b.imm = {w[31:12], 12'h000};
            F_J:     b.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            F_Z:     b.imm = 32'(w[19:15]);
            default: b.imm = 32'hFFFF_FFFF;
        endcase
        return b;
    endfunction

    // Illegal instructions carry no defined immediate or ALU op.
    function automatic bun_t canon(bun_t b);
        if (b.ill) begin
            b.imm = '0;
            b.alu = '0;
        end
        return b;
    endfunction

    function automatic bun_t dut_bun();
        bun_t b;
        b.pc = out_pc; b.imm = out_imm; b.rs1 = out_rs1_addr; b.rs2 = out_rs2_addr;
        b.rd = out_rd_addr; b.alu = out_alu_op; b.wen = out_rd_wen; b.md = out_muldiv;
        b.mdop = out_muldiv_op; b.ill = out_illegal;
        return b;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 12))
            0:  w[6:0] = 7'h37;
            1:  w[6:0] = 7'h17;
            2:  w[6:0] = 7'h6F;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h03;
            6:  w[6:0] = 7'h23;
            7:  w[6:0] = 7'h13;
            8: begin
                w[6:0] = 7'h33;
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
            9:  w[6:0] = 7'h0F;
            10: begin
                w[6:0] = 7'h73;
                case ($urandom_range(0, 4))
                    0: w = 32'h0000_0073;
                    1: w = 32'h0010_0073;
                    2: w = 32'h3020_0073;
                    default: ;
                endcase
            end
            11: begin
                w[6:0]   = 7'h13;
                w[14:12] = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
                w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            end
            default: ;
        endcase
        return w;
    endfunction

    // Advance one clock: model reacts to the inputs present at the edge.
    task automatic tick();
        bit acc, deq;
        acc = in_valid && ((mq.size() < DEPTH) || out_ready) && !flush;
        deq = (mq.size() > 0) && out_ready && !flush;
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (deq) void'(mq.pop_front());
            if (acc) mq.push_back(ref_decode(in_ins, in_pc, 1'b1));
        end
        last_acc = acc;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; in_ins = 0; in_pc = 0; flush = 0; out_ready = 0;
        m0_in_valid = 0; m0_in_ins = 0; m0_in_pc = 0; m0_flush = 0; m0_out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", count); end
        n_vec++; if (dut_bun() !== bun_t'(0)) begin n_err++; $display("FAIL reset_fields got=%h want=0", dut_bun()); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi();
        in_valid = 1; in_ins = 32'hFFD0_8293; in_pc = 32'h100; out_ready = 1;
        tick();
        in_valid = 0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got=%0b want=1", out_valid); end
        n_vec++; if (out_imm !== 32'hFFFF_FFFD || out_rd_addr !== 5'd5 || out_rs1_addr !== 5'd1
                     || out_rd_wen !== 1'b1 || out_alu_op !== A_ADD || out_illegal !== 1'b0) begin
            n_err++; $display("FAIL addi_fields got imm=%h rd=%0d rs1=%0d wen=%0b alu=%0d want imm=fffffffd rd=5 rs1=1 wen=1 alu=0",
                              out_imm, out_rd_addr, out_rs1_addr, out_rd_wen, out_alu_op);
        end
        n_vec++; if (canon(dut_bun()) !== canon(mq[0])) begin n_err++; $display("FAIL addi_model got=%h want=%h", dut_bun(), mq[0]); end
        tick();
        n_vec++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL addi_drain got count=%0d valid=%0b want 0 0", count, out_valid); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] seen [$];
        int cyc;
        out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1; in_ins = rand_ins(); in_pc = 32'h1000 + 32'(4 * k);
            if (k < 4) tick();
        end
        #1;
        n_vec++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_err++; $display("FAIL fill_full got count=%0d ready=%0b want 4 0", count, in_ready); end
        tick();
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_hold got=%0d want=4", count); end
        out_ready = 1;
        cyc = 0;
        while ((mq.size() > 0 || in_valid) && cyc < 20) begin
            if (out_valid && out_ready) seen.push_back(out_pc);
            tick();
            if (last_acc) in_valid = 0;
            if (mq.size() > 0) begin
                n_vec++; if (canon(dut_bun()) !== canon(mq[0])) begin n_err++; $display("FAIL drain_head got=%h want=%h", dut_bun(), mq[0]); end
            end
            cyc++;
        end
        n_vec++; if (seen.size() != 5 || out_valid !== 1'b0) begin n_err++; $display("FAIL drain_total got=%0d valid=%0b want 5 0", seen.size(), out_valid); end
        for (int k = 0; k < seen.size(); k++) begin
            n_vec++; if (seen[k] !== 32'h1000 + 32'(4 * k)) begin n_err++; $display("FAIL drain_order idx=%0d got=%h want=%h", k, seen[k], 32'h1000 + 32'(4 * k)); end
        end
    endtask

    task automatic test_back_to_back();
        int taken = 0;
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; in_ins = rand_ins(); in_pc = 32'h2000 + 32'(4 * k);
            tick();
        end
        out_ready = 1;
        for (int k = 0; k < 10; k++) begin
            in_ins = rand_ins(); in_pc = 32'h3000 + 32'(4 * k);
            #1;
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%0b want=1", in_ready); end
            tick();
            if (last_acc) taken++;
            n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL b2b_count got=%0d want=4", count); end
            n_vec++; if (canon(dut_bun()) !== canon(mq[0])) begin n_err++; $display("FAIL b2b_head got=%h want=%h", dut_bun(), mq[0]); end
        end
        n_vec++; if (taken != 10) begin n_err++; $display("FAIL b2b_throughput got=%0d want=10", taken); end
        in_valid = 0;
        for (int k = 0; k < 6 && mq.size() > 0; k++) tick();
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL b2b_empty got=%0d want=0", count); end
    endtask

    task automatic test_muldiv();
        in_valid = 1; in_ins = 32'h0220_81B3; in_pc = 32'h400; out_ready = 1;
        m0_in_valid = 1; m0_in_ins = 32'h0220_81B3; m0_in_pc = 32'h400; m0_out_ready = 1;
        tick();
        in_valid = 0; m0_in_valid = 0;
        n_vec++; if (out_muldiv !== 1'b1 || out_muldiv_op !== 3'd0 || out_illegal !== 1'b0 || out_rd_wen !== 1'b1 || out_alu_op !== 4'd0) begin
            n_err++; $display("FAIL mul_m1 got md=%0b op=%0d ill=%0b wen=%0b alu=%0d want 1 0 0 1 0", out_muldiv, out_muldiv_op, out_illegal, out_rd_wen, out_alu_op);
        end
        n_vec++; if (m0_out_valid !== 1'b1 || m0_ill !== 1'b1 || m0_wen !== 1'b0 || m0_md !== 1'b0) begin
            n_err++; $display("FAIL mul_m0 got valid=%0b ill=%0b wen=%0b md=%0b want 1 1 0 0", m0_out_valid, m0_ill, m0_wen, m0_md);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; in_ins = rand_ins(); in_pc = 32'h5000 + 32'(4 * k);
            tick();
        end
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre got=%0d want=3", count); end
        flush = 1; in_valid = 1; in_ins = 32'h0010_0093; in_pc = 32'hDEAD_0000; out_ready = 1;
        tick();
        flush = 0; in_valid = 0;
        n_vec++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_clear got count=%0d valid=%0b want 0 0", count, out_valid); end
        tick();
        n_vec++; if (out_valid !== 1'b0 || out_pc === 32'hDEAD_0000) begin n_err++; $display("FAIL flush_ghost got valid=%0b pc=%h want valid 0", out_valid, out_pc); end
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; in_ins = rand_ins(); in_pc = 32'h6000 + 32'(4 * k);
            tick();
        end
        in_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL arst_clear got valid=%0b count=%0d want 0 0", out_valid, count); end
        mq.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        in_valid = 1; in_ins = 32'h0000_0073; in_pc = 32'h7000; out_ready = 0;
        tick();
        in_valid = 0;
        n_vec++; if (out_valid !== 1'b1 || out_illegal !== 1'b0 || out_rd_wen !== 1'b0) begin
            n_err++; $display("FAIL ecall got valid=%0b ill=%0b wen=%0b want 1 0 0", out_valid, out_illegal, out_rd_wen);
        end
        n_vec++; if (canon(dut_bun()) !== canon(mq[0])) begin n_err++; $display("FAIL ecall_model got=%h want=%h", dut_bun(), mq[0]); end
        out_ready = 1;
        tick();
    endtask

    task automatic test_random();
        bit          last_flush = 1'b0;
        logic [31:0] pc_ctr = 32'h8000;
        bit          exp_ready;
        last_acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!(in_valid && !last_acc && !last_flush)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_ins   = rand_ins();
                in_pc    = pc_ctr;
                pc_ctr   = pc_ctr + 4;
            end
            flush      = ($urandom_range(0, 19) == 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            last_flush = flush;
            exp_ready  = (mq.size() < DEPTH) || out_ready;
            #1;
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", c, in_ready, exp_ready); end
            tick();
            n_vec++; if (count !== 3'(mq.size()) || out_valid !== (mq.size() > 0)) begin
                n_err++; $display("FAIL rnd_count cyc=%0d got count=%0d valid=%0b want %0d %0b", c, count, out_valid, mq.size(), mq.size() > 0);
            end
            if (mq.size() > 0) begin
                n_vec++; if (canon(dut_bun()) !== canon(mq[0])) begin n_err++; $display("FAIL rnd_head cyc=%0d got=%h want=%h", c, dut_bun(), mq[0]); end
            end
        end
        flush = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_fill_drain();
        test_back_to_back();
        test_muldiv();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
